digital_lock: RTL and testbench



---
 rtl/digital_lock_pkg.sv | 30 +++
 rtl/digital_lock_key_press_detector.sv | 27 ++
 rtl/digital_lock.sv | 175 +++++++++++++++++
 tb/tb_digital_lock.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/digital_lock_pkg.sv
// Shared encodings and sizing helpers for the keypad lock controller.
package digital_lock_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef enum logic [2:0] {
    U_IDLE    = 3'd0,
    U_ENTER1  = 3'd1,
    U_ENTER2  = 3'd2,
    U_COMPARE = 3'd3,
    U_FAIL    = 3'd4
  } unlocked_state_e;

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_ENTER   = 2'd1,
    L_COMPARE = 2'd2,
    L_FAIL    = 2'd3
  } locked_state_e;

  function automatic int unsigned code_width(input int unsigned len);
    return KEY_W * len;
  endfunction

endpackage

// File: rtl/digital_lock_key_press_detector.sv
// Turns a debounced keypad level into a one-cycle press strobe plus the key value.
module key_press_detector
  import digital_lock_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] key,
  output logic             press,
  output logic [KEY_W-1:0] value
);

  logic [KEY_W-1:0] key_prev;

  // A press is a transition from no key to any key; holding does not repeat.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_prev <= '0;
      press    <= 1'b0;
      value    <= '0;
    end else begin
      key_prev <= key;
      press    <= (key_prev == '0) && (key != '0);
      value    <= key;
    end
  end

endmodule

// File: rtl/digital_lock.sv
// Keypad lock: set a code by entering it twice while unlocked, reopen by entering it while locked.
module digital_lock
  import digital_lock_pkg::*;
#(
  parameter int unsigned PASSCODE_LENGTH = 3,
  parameter int unsigned CLOCK_FREQ      = 50000000,
  parameter int unsigned TIMEOUT_SEC     = 5
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [KEY_W-1:0]                         key,
  output logic                                     locked,
  output logic                                     error,
  output logic [code_width(PASSCODE_LENGTH)-1:0]   entry,
  output logic [1:0]                               entry_counter,
  output logic                                     state,
  output logic [2:0]                               substate_unlocked,
  output logic [1:0]                               substate_locked
);

  localparam int unsigned CODE_W         = code_width(PASSCODE_LENGTH);
  localparam int unsigned CNT_W          = (PASSCODE_LENGTH > 4) ? 3 : 2;
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_SEC * CLOCK_FREQ;
  localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

  logic             press;
  logic [KEY_W-1:0] value;

  key_press_detector u_kpd (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .press (press),
    .value (value)
  );

  lock_state_e     state_q, state_d;
  unlocked_state_e sub_u_q, sub_u_d;
  locked_state_e   sub_l_q, sub_l_d;
  logic [CODE_W-1:0] entry_q, entry_d, code_q, code_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              locked_q, locked_d, error_q, error_d;
  logic              complete, active, tmo_fire;

  assign shifted  = {entry_q[CODE_W-KEY_W-1:0], value};
  assign complete = press && (cnt_q == CNT_W'(PASSCODE_LENGTH - 1));
  assign active   = (state_q == UNLOCKED) ? (sub_u_q != U_IDLE) : (sub_l_q != L_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      sub_u_q  <= U_IDLE;
      sub_l_q  <= L_IDLE;
      entry_q  <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_u_q  <= sub_u_d;
      sub_l_q  <= sub_l_d;
      entry_q  <= entry_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sub_u_d  = sub_u_q;
    sub_l_d  = sub_l_q;
    entry_d  = entry_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    error_d  = error_q;
    tmo_fire = 1'b0;

    // Digit capture and inactivity counting, common to both modes.
    if (press) begin
      entry_d = shifted;
      cnt_d   = complete ? '0 : CNT_W'(cnt_q + 1'b1);
      tmo_d   = '0;
      error_d = 1'b0;
    end else if (!active) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_fire = 1'b1;
      tmo_d    = '0;
    end else begin
      tmo_d = TMO_W'(tmo_q + 1'b1);
    end

    if (state_q == UNLOCKED) begin
      unique case (sub_u_q)
        U_IDLE:   if (press) sub_u_d = U_ENTER1;
        U_ENTER1: if (complete) begin
          code_d  = shifted;
          entry_d = '0;
          sub_u_d = U_ENTER2;
        end
        U_ENTER2: if (complete) sub_u_d = U_COMPARE;
        U_COMPARE: begin
          if (entry_q == code_q) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            error_d  = 1'b0;
            sub_l_d  = L_IDLE;
            sub_u_d  = U_IDLE;
          end else begin
            error_d = 1'b1;
            sub_u_d = U_FAIL;
          end
        end
        U_FAIL: begin
          entry_d = '0;
          cnt_d   = '0;
          sub_u_d = U_IDLE;
        end
        default: sub_u_d = U_IDLE;
      endcase
    end else begin
      unique case (sub_l_q)
        L_IDLE:  if (press) sub_l_d = L_ENTER;
        L_ENTER: if (complete) sub_l_d = L_COMPARE;
        L_COMPARE: begin
          if (entry_q == code_q) begin
            state_d  = UNLOCKED;
            locked_d = 1'b0;
            error_d  = 1'b0;
            sub_u_d  = U_IDLE;
            sub_l_d  = L_IDLE;
          end else begin
            error_d = 1'b1;
            sub_l_d = L_FAIL;
          end
        end
        L_FAIL: begin
          entry_d = '0;
          cnt_d   = '0;
          sub_l_d = L_IDLE;
        end
        default: sub_l_d = L_IDLE;
      endcase
    end

    // An abandoned entry is discarded; an unconfirmed code is forgotten too.
    if (tmo_fire) begin
      entry_d = '0;
      cnt_d   = '0;
      if (state_q == UNLOCKED) begin
        sub_u_d = U_IDLE;
        code_d  = '0;
      end else begin
        sub_l_d = L_IDLE;
      end
    end
  end

  assign locked            = locked_q;
  assign error             = error_q;
  assign entry             = entry_q;
  assign entry_counter     = cnt_q[1:0];
  assign state             = state_q;
  assign substate_unlocked = sub_u_q;
  assign substate_locked   = sub_l_q;

endmodule

// File: tb/tb_digital_lock.sv
// Directed plus randomized bench for digital_lock against a code-level reference model.
module tb_digital_lock;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 4 * N;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    key   = 4'b0000;
  logic          locked, error, state;
  logic [CW-1:0] entry;
  logic [1:0]    entry_counter;
  logic [2:0]    substate_unlocked;
  logic [1:0]    substate_locked;

  int total = 0;
  int bad   = 0;

  // Reference model: whether the device is locked, the error flag, the code that opens it.
  bit          locked_m = 1'b0;
  bit          error_m  = 1'b0;
  int unsigned code_m   = 0;

  digital_lock #(
    .PASSCODE_LENGTH (N),
    .CLOCK_FREQ      (10),
    .TIMEOUT_SEC     (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .key               (key),
    .locked            (locked),
    .error             (error),
    .entry             (entry),
    .entry_counter     (entry_counter),
    .state             (state),
    .substate_unlocked (substate_unlocked),
    .substate_locked   (substate_locked)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] v);
    key = v;
    tick(1);
    key = 4'b0000;
    tick(1);
  endtask

  // Digits are taken most-significant nibble first.
  task automatic enter_code(input int unsigned c);
    for (int i = N - 1; i >= 0; i--) press_key(4'((c >> (4 * i)) & 15));
  endtask

  function automatic int unsigned rand_code();
    int unsigned c = 0;
    for (int i = 0; i < N; i++) c = c * 16 + $urandom_range(1, 15);
    return c;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".locked"}, 32'(locked), 32'(locked_m));
    check({tag, ".error"},  32'(error),  32'(error_m));
    check({tag, ".state"},  32'(state),  32'(locked_m));
  endtask

  task automatic try_set(input int unsigned a, input int unsigned b);
    enter_code(a);
    enter_code(b);
    tick(5);
    if (a == b) begin
      locked_m = 1'b1;
      code_m   = a;
      error_m  = 1'b0;
    end else begin
      error_m = 1'b1;
      check("set_fail.entry", 32'(entry), 32'd0);
      check("set_fail.sub_u", 32'(substate_unlocked), 32'd0);
    end
    check_status("set");
  endtask

  task automatic try_unlock(input int unsigned a);
    enter_code(a);
    tick(5);
    if (a == code_m) begin
      locked_m = 1'b0;
      error_m  = 1'b0;
    end else begin
      error_m = 1'b1;
      check("unlock_fail.entry", 32'(entry), 32'd0);
      check("unlock_fail.sub_l", 32'(substate_locked), 32'd0);
    end
    check_status("unlock");
  endtask

  initial begin
    int unsigned a, b, w;

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst.locked", 32'(locked), 32'd0);
    check("rst.error", 32'(error), 32'd0);
    check("rst.state", 32'(state), 32'd0);
    check("rst.entry", 32'(entry), 32'd0);
    check("rst.counter", 32'(entry_counter), 32'd0);
    check("rst.sub_u", 32'(substate_unlocked), 32'd0);
    check("rst.sub_l", 32'(substate_locked), 32'd0);

    try_set(32'h142, 32'h142);
    try_unlock(32'h144);
    try_unlock(32'h142);
    try_set(32'h142, 32'h112);

    // Held key: one press only, and it clears the pending error.
    key = 4'b0010;
    tick(10);
    error_m = 1'b0;
    check("hold.counter", 32'(entry_counter), 32'd1);
    check("hold.entry", 32'(entry), 32'h2);
    check("hold.error", 32'(error), 32'(error_m));
    check("hold.sub_u", 32'(substate_unlocked), 32'd1);
    key = 4'b0000;
    tick(14);
    check("hold_tmo.counter", 32'(entry_counter), 32'd0);
    check("hold_tmo.sub_u", 32'(substate_unlocked), 32'd0);

    // Partial entry abandoned while unlocked.
    press_key(4'h1);
    press_key(4'h2);
    tick(12);
    check("tmo_u.entry", 32'(entry), 32'd0);
    check("tmo_u.counter", 32'(entry_counter), 32'd0);
    check("tmo_u.sub_u", 32'(substate_unlocked), 32'd0);
    check_status("tmo_u");

    // Partial entry abandoned while locked: stays locked, code kept.
    try_set(32'h3a5, 32'h3a5);
    press_key(4'h3);
    press_key(4'ha);
    tick(12);
    check("tmo_l.entry", 32'(entry), 32'd0);
    check("tmo_l.counter", 32'(entry_counter), 32'd0);
    check("tmo_l.sub_l", 32'(substate_locked), 32'd0);
    check_status("tmo_l");
    try_unlock(32'h3a5);

    for (int t = 0; t < 20; t++) begin
      a = rand_code();
      b = ($urandom_range(0, 1) == 1) ? a : rand_code();
      try_set(a, b);
      if (locked_m && $urandom_range(0, 2) == 0) begin
        w = rand_code();
        try_unlock(w);
      end
      if (locked_m) try_unlock(code_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
